// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data memory controller.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        INIT,
        CLEAR,
        READY
    } state_t;

    function automatic logic [3:0] store_be(
        input logic [1:0] size,
        input logic [1:0] off
    );
        store_be = 4'b0000;
        unique case (1'b1)
            size == SIZE_B: store_be = 4'b0001 << off;
            size == SIZE_H: store_be = off[1] ? 4'b1100 : 4'b0011;
            size == SIZE_W: store_be = 4'b1111;
            default:        store_be = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed lane of a load word and sign/zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = 8'(word >> {off, 3'b000});
        h    = off[1] ? word[31:16] : word[15:0];
        data = '0;
        unique case (1'b1)
            size == SIZE_B: data = uns ? {24'b0, b} : {{24{b[7]}}, b};
            size == SIZE_H: data = uns ? {16'b0, h} : {{16{h[15]}}, h};
            size == SIZE_W: data = word;
            default:        data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data RAM with byte/half/word access, error responses,
// configurable read latency and an optional post-reset clear sweep.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 256,
    parameter int READ_LAT       = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_writeData,
    output logic        o_rsp_valid,
    output logic [31:0] o_readData,
    output logic        o_rsp_err,
    output logic        o_busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state, state_nx;
    logic [AW-1:0] clr_idx;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          bad_size, misalign, oor, err;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word, ld_data, rsp_data;

    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wd;
    logic [AW-1:0] mem_idx;

    logic          r1_valid, r1_err;
    logic [31:0]   r1_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= INIT;
            clr_idx <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        o_busy      = 1'b0;
        o_req_ready = 1'b0;
        unique case (state)
            INIT:  state_nx = CLEAR_ON_RESET ? CLEAR : READY;
            CLEAR: begin
                o_busy = 1'b1;
                if (&clr_idx) state_nx = READY;
            end
            READY: o_req_ready = 1'b1;
            default: state_nx = INIT;
        endcase
    end

    assign accept   = i_req_valid && o_req_ready;
    assign bad_size = i_req_size == 2'b11;
    assign misalign = (i_req_size == SIZE_H && i_addr[0]) ||
                      (i_req_size == SIZE_W && i_addr[1:0] != 2'b00);
    assign oor      = |i_addr[31:AW+2];
    assign err      = bad_size || misalign || oor;
    assign idx      = i_addr[AW+1:2];
    assign rd_word  = mem[idx];

    dmem_load_align u_align (
        .word (rd_word),
        .off  (i_addr[1:0]),
        .size (i_req_size),
        .uns  (i_req_unsigned),
        .data (ld_data)
    );

    assign rsp_data = (i_req_we || err) ? 32'h0 : ld_data;

    // The clear sweep owns the single write port until READY.
    always_comb begin
        mem_we  = 1'b0;
        mem_be  = 4'b0000;
        mem_wd  = '0;
        mem_idx = idx;
        if (state == CLEAR) begin
            mem_we  = 1'b1;
            mem_be  = 4'b1111;
            mem_idx = clr_idx;
        end else if (accept && i_req_we && !err) begin
            mem_we = 1'b1;
            mem_be = store_be(i_req_size, i_addr[1:0]);
            unique case (1'b1)
                i_req_size == SIZE_B: mem_wd = {4{i_writeData[7:0]}};
                i_req_size == SIZE_H: mem_wd = {2{i_writeData[15:0]}};
                default:              mem_wd = i_writeData;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int l = 0; l < 4; l++) begin
                if (mem_be[l]) mem[mem_idx][8*l +: 8] <= mem_wd[8*l +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r1_valid <= 1'b0;
            r1_err   <= 1'b0;
            r1_data  <= '0;
        end else begin
            r1_valid <= accept;
            if (accept) begin
                r1_err  <= err;
                r1_data <= rsp_data;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic        r2_valid, r2_err;
            logic [31:0] r2_data;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r2_valid <= 1'b0;
                    r2_err   <= 1'b0;
                    r2_data  <= '0;
                end else begin
                    r2_valid <= r1_valid;
                    if (r1_valid) begin
                        r2_err  <= r1_err;
                        r2_data <= r1_data;
                    end
                end
            end

            assign o_rsp_valid = r2_valid;
            assign o_rsp_err   = r2_err;
            assign o_readData  = r2_data;
        end else begin : g_lat1
            assign o_rsp_valid = r1_valid;
            assign o_rsp_err   = r1_err;
            assign o_readData  = r1_data;
        end
    endgenerate

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench driving a READ_LAT=1 and a READ_LAT=2 instance in lockstep.
module tb_data_memory_ctrl;
    import dmem_pkg::*;

    logic        clk, rst_n;
    logic        req_valid, req_we, req_uns;
    logic [1:0]  req_size;
    logic [31:0] addr, wd;

    logic        rdy1, v1, e1, busy1;
    logic [31:0] d1;
    logic        rdy2, v2, e2, busy2;
    logic [31:0] d2;

    int n_tests = 0;
    int n_fail  = 0;

    logic        p1_v, p1_e, p2_v, p2_e;
    logic [31:0] p1_d, p2_d;

    data_memory_ctrl #(.DEPTH_WORDS(16), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u_lat1 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (rdy1),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_uns),
        .i_addr         (addr),
        .i_writeData    (wd),
        .o_rsp_valid    (v1),
        .o_readData     (d1),
        .o_rsp_err      (e1),
        .o_busy         (busy1)
    );

    data_memory_ctrl #(.DEPTH_WORDS(16), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)) u_lat2 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (rdy2),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_uns),
        .i_addr         (addr),
        .i_writeData    (wd),
        .o_rsp_valid    (v2),
        .o_readData     (d2),
        .o_rsp_err      (e2),
        .o_busy         (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] xd, input logic xe);
        req_valid = v;
        req_we    = we;
        req_size  = sz;
        req_uns   = uns;
        addr      = a;
        wd        = w;
        step();
        req_valid = 1'b0;
        p2_v = p1_v; p2_d = p1_d; p2_e = p1_e;
        p1_v = v;    p1_d = xd;   p1_e = xe;
        chk("lat1_valid", 32'(v1), 32'(p1_v));
        if (p1_v) begin
            chk("lat1_data", d1, p1_d);
            chk("lat1_err", 32'(e1), 32'(p1_e));
        end
        chk("lat2_valid", 32'(v2), 32'(p2_v));
        if (p2_v) begin
            chk("lat2_data", d2, p2_d);
            chk("lat2_err", 32'(e2), 32'(p2_e));
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, SIZE_W, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic flush_pipe();
        p1_v = 1'b0; p1_d = '0; p1_e = 1'b0;
        p2_v = 1'b0; p2_d = '0; p2_e = 1'b0;
    endtask

    // Called right after reset release, while still in INIT.
    task automatic wait_clear(input string tag);
        int n1;
        int n2;
        n1 = 0;
        n2 = 0;
        chk({tag, "_init_busy"}, 32'({busy1, busy2}), 32'h0);
        chk({tag, "_init_ready"}, 32'({rdy1, rdy2}), 32'h0);
        step();
        for (int i = 0; i < 40 && (busy1 || busy2); i++) begin
            if (busy1) n1++;
            if (busy2) n2++;
            chk({tag, "_clr_ready"}, 32'({rdy1, rdy2}), 32'h0);
            chk({tag, "_clr_rsp"}, 32'({v1, v2}), 32'h0);
            step();
        end
        chk({tag, "_busy_cycles1"}, 32'(n1), 32'd16);
        chk({tag, "_busy_cycles2"}, 32'(n2), 32'd16);
        chk({tag, "_ready_after"}, 32'({rdy1, rdy2}), 32'h3);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = SIZE_W;
        req_uns   = 1'b0;
        addr      = '0;
        wd        = '0;
        flush_pipe();

        repeat (3) step();
        chk("rst_ready", 32'({rdy1, rdy2}), 32'h0);
        chk("rst_valid", 32'({v1, v2}), 32'h0);
        chk("rst_err", 32'({e1, e2}), 32'h0);
        chk("rst_busy", 32'({busy1, busy2}), 32'h0);
        chk("rst_data1", d1, 32'h0);
        chk("rst_data2", d2, 32'h0);

        rst_n = 1'b1;
        wait_clear("boot");

        cyc(1, 0, SIZE_W, 0, 32'h3C, 32'h0, 32'h00000000, 0);

        cyc(1, 1, SIZE_W, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0);
        cyc(1, 0, SIZE_B, 0, 32'h0B, 32'h0, 32'hFFFFFFDE, 0);
        cyc(1, 0, SIZE_B, 1, 32'h0B, 32'h0, 32'h000000DE, 0);
        cyc(1, 0, SIZE_H, 0, 32'h08, 32'h0, 32'hFFFFBEEF, 0);
        cyc(1, 0, SIZE_H, 1, 32'h0A, 32'h0, 32'h0000DEAD, 0);
        idle();

        cyc(1, 1, SIZE_W, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0);
        cyc(1, 1, SIZE_B, 0, 32'h09, 32'hAAAAAA55, 32'h0, 0);
        cyc(1, 0, SIZE_W, 0, 32'h08, 32'h0, 32'hDEAD55EF, 0);
        idle();

        cyc(1, 0, SIZE_W, 0, 32'h06, 32'h0, 32'h0, 1);
        cyc(1, 1, SIZE_H, 0, 32'h05, 32'h00001234, 32'h0, 1);
        cyc(1, 0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 1);
        cyc(1, 1, 2'b11, 0, 32'h04, 32'hFFFFFFFF, 32'h0, 1);
        cyc(1, 0, SIZE_W, 0, 32'h40, 32'h0, 32'h0, 1);
        cyc(1, 1, SIZE_W, 0, 32'h44, 32'hCAFEF00D, 32'h0, 1);
        cyc(1, 0, SIZE_W, 0, 32'h04, 32'h0, 32'h00000000, 0);
        cyc(1, 1, SIZE_H, 0, 32'h06, 32'hFFFF1234, 32'h0, 0);
        cyc(1, 0, SIZE_W, 0, 32'h04, 32'h0, 32'h12340000, 0);
        idle();
        idle();

        // Reset part-way through the clear sweep, at index 5.
        rst_n = 1'b0;
        flush_pipe();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("mid_clr_busy", 32'({busy1, busy2}), 32'h3);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("mid_clr_rst_busy", 32'({busy1, busy2}), 32'h0);
        chk("mid_clr_rst_ready", 32'({rdy1, rdy2}), 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_clear("reclr");

        cyc(1, 0, SIZE_W, 0, 32'h04, 32'h0, 32'h00000000, 0);
        cyc(1, 1, SIZE_W, 0, 32'h0C, 32'h11223344, 32'h0, 0);
        cyc(1, 0, SIZE_W, 0, 32'h0C, 32'h0, 32'h11223344, 0);

        // Second load presented while the first is still in the lat2 pipe.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = SIZE_W;
        addr      = 32'h08;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        req_valid = 1'b0;
        flush_pipe();
        chk("flight_rst_valid", 32'({v1, v2}), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flight_hold_valid", 32'({v1, v2}), 32'h0);
        end
        rst_n = 1'b1;
        wait_clear("flight");

        cyc(1, 0, SIZE_W, 0, 32'h0C, 32'h0, 32'h00000000, 0);
        cyc(1, 0, SIZE_W, 0, 32'h08, 32'h0, 32'h00000000, 0);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised RISC-V data memory with a request/response handshake. It supports byte, half and word access, sign- or zero-extension on loads, and error responses for misaligned or out-of-range accesses. It has a configurable read latency, and an optional hardware clear sequence that zeroes the whole array after reset. It sits between the core's memory stage and the word-organised data RAM, and it replaces the flat single-cycle data memory.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..65536.
READ_LAT, 1, cycles from request accept to response; legal values 1 or 2.
CLEAR_ON_RESET, 1, when 1, every word is zeroed after reset release before the first request is accepted.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous reset, active-low.
i_req_valid  in  1  request present.
o_req_ready  out  1  block can accept a request this cycle.
i_req_we  in  1  1 = store, 0 = load.
i_req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and flags an error.
i_req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
i_addr  in  32  byte address.
i_writeData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
o_rsp_valid  out  1  one-cycle response pulse.
o_readData  out  32  extended load data; 0 for stores and for errors.
o_rsp_err  out  1  misaligned, out-of-range or illegal size; qualified by o_rsp_valid.
o_busy  out  1  clear sequence in progress.

Behaviour:
- Reset values while i_rst_n is low:
  - o_req_ready=0, o_rsp_valid=0, o_readData=0, o_rsp_err=0, o_busy=0.
  - FSM in INIT; pipeline valid bits cleared.
- FSM, states INIT, CLEAR, READY:
  - INIT goes to CLEAR on the first clock after release if CLEAR_ON_RESET=1, otherwise to READY.
  - CLEAR writes 0 to index 0..DEPTH_WORDS-1, one word per cycle, then goes to READY. o_busy=1 and o_req_ready=0 throughout.
  - READY: o_req_ready=1 permanently; the state is never left except by reset.
- Reset asserted mid-CLEAR or mid-request: all in-flight responses are dropped with no o_rsp_valid, and CLEAR restarts at index 0.
- Accept: a request is accepted on a rising edge where i_req_valid && o_req_ready. Throughput is one request per cycle. There is no response backpressure.
- Error check at accept, with priority illegal size > misaligned > out-of-range:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out-of-range: addr[31:2] >= DEPTH_WORDS.
  - An errored store writes nothing. An errored load returns 0.
- Store lanes, with the write committed on the accept edge:
  - Byte: byte lane addr[1:0] gets wd[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get wd[15:0].
  - Word: all four lanes.
  - Untouched lanes keep their value.
- Load: the word is read at accept, then the lane is extracted and extended.
  - READ_LAT=1: the response is registered on the accept edge and visible the next cycle.
  - READ_LAT=2: one extra output register.
- Response: o_rsp_valid pulses exactly READ_LAT cycles after accept, for both loads and stores. Responses return in order.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. There is no same-cycle hazard because the block has a single port.
- Between responses o_readData holds its last value; only o_rsp_valid qualifies it.

Decomposition:
- Package dmem_pkg holds:
  - the size encoding constants SIZE_B/SIZE_H/SIZE_W;
  - the FSM state enum {INIT, CLEAR, READY};
  - a store byte-enable function (size, addr[1:0]) -> 4-bit mask.
- Natural sub-module: dmem_load_align. It is combinational and maps (word, addr[1:0], size, unsigned) to the 32-bit extended result.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH_WORDS=16 -> o_busy high for exactly 16 cycles after INIT, o_req_ready rises the following cycle; a load word at 0x3C returns 0x00000000.
- SW 0xDEADBEEF @0x08, then LB @0x0B -> 0xFFFFFFDE; LBU @0x0B -> 0x000000DE; LH @0x08 -> 0xFFFFBEEF; LHU @0x0A -> 0x0000DEAD; each o_rsp_valid arrives READ_LAT cycles after its accept.
- SW 0xDEADBEEF @0x08, SB 0x55 @0x09, LW @0x08 in back-to-back cycles -> 0xDEAD55EF, one response per cycle.
- LW @0x06, SH 0x1234 @0x05, size=11, LW @(DEPTH_WORDS*4) -> each gives o_rsp_err=1 with o_readData=0; a following LW @0x04 shows the memory unchanged.
- Reset asserted at clear index 5 and while two loads are in flight -> no o_rsp_valid, and after release o_busy lasts the full DEPTH_WORDS cycles again.
- Repeat the second and third scenarios with READ_LAT=2 -> same data, with responses shifted by one cycle.
